// File: rtl/game2048_pkg.sv
// Shared 2048 definitions: one-hot direction codes and the input-conditioner FSM states.
// The game FSM imports this package too, so both sides agree on the encodings.
package game2048_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ARMED,
    HOLD,
    WAIT_RELEASE
  } dir_fsm_t;

  // True only when exactly one bit is set (zero is not one-hot).
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/direction_input_if.sv
// Button-to-game bus: raw buttons in, direction command and debug state out.
interface direction_input_if;
  logic [3:0] btn_raw;
  logic [3:0] direction;
  logic       key_valid;
  logic [3:0] btn_stable;

  modport master (output btn_raw, input direction, key_valid, btn_stable);
  modport slave  (input btn_raw, output direction, key_valid, btn_stable);
endinterface

// File: rtl/debounce_bit.sv
// One button: 2-flop synchroniser, polarity normalisation and disagreement counter.
// The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable
);

  localparam int   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic IDLE_LVL = BTN_ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic [CW-1:0] cnt;

  assign pressed = sync2 ^ IDLE_LVL;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= IDLE_LVL;
      sync2      <= IDLE_LVL;
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // Any agreeing sample restarts the count, so short glitches never flip.
      if (pressed == btn_stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable <= ~btn_stable;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/direction_input.sv
// Input conditioner for the 2048 game: debounces four buttons and emits one
// one-hot direction burst of HOLD_CYCLES per clean single-button press.
module direction_input
  import game2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  direction_input_if.slave  bus
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  logic [3:0]     stable;
  dir_fsm_t       state_q, state_d;
  logic [3:0]     dir_q, dir_d;
  logic           kv_q, kv_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_db
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
      ) u_db (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (bus.btn_raw[i]),
        .btn_stable (stable[i])
      );
    end
  endgenerate

  assign bus.btn_stable = stable;
  assign bus.direction  = dir_q;
  assign bus.key_valid  = kv_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARMED;
      dir_q   <= DIR_NONE;
      kv_q    <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      kv_q    <= kv_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // dir_q doubles as the latched command; btn_stable is ignored while in HOLD.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    kv_d    = 1'b0;
    hcnt_d  = hcnt_q;
    case (state_q)
      ARMED: begin
        if (is_onehot4(stable)) begin
          dir_d   = stable;
          kv_d    = 1'b1;
          hcnt_d  = HCW'(1);
          state_d = HOLD;
        end else if (stable != DIR_NONE) begin
          state_d = WAIT_RELEASE;
        end
      end
      HOLD: begin
        if (hcnt_q < HCW'(HOLD_CYCLES)) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          dir_d   = DIR_NONE;
          hcnt_d  = '0;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (stable == DIR_NONE) state_d = ARMED;
      end
      default: begin
        dir_d   = DIR_NONE;
        hcnt_d  = '0;
        state_d = ARMED;
      end
    endcase
  end

endmodule

// File: doc/direction_input.md
Name: direction_input

Overview:
- Input conditioner directly upstream of the 2048 game FSM.
- Takes the four raw push-button lines (up, down, left, right) and synchronises and debounces them.
- Emits exactly one one-hot direction command per physical press, held for a fixed number of cycles so the game's IDLE to MOVE_MERGE path samples it reliably.
- Chorded (multi-button) presses and repeated presses while a button is held are suppressed.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised input must disagree with its stable value before the stable value flips (10 ms at 50 MHz); minimum 2.
- HOLD_CYCLES, 4, cycles `direction` stays asserted per press; minimum 1.
- BTN_ACTIVE_LOW, 1, 1 means `btn_raw` bit = 0 when pressed; 0 means active-high.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (0 = reset)
- btn_raw  input  4  asynchronous buttons; bit0 up, bit1 down, bit2 left, bit3 right
- direction  output  4  one-hot command to the game: 0001 top, 0010 bottom, 0100 left, 1000 right; 0000 = none
- key_valid  output  1  one-cycle pulse on the first cycle `direction` is non-zero
- btn_stable  output  4  debounced pressed state, active-high, for debug/LEDs

Behaviour:
Reset (rst == 0 at a clk edge):
- Synchroniser flops load the "not pressed" level.
- `btn_stable` = 0000, all debounce counters = 0, hold counter = 0.
- `direction` = 0000, `key_valid` = 0.
- FSM goes to ARMED.
- Reset has priority at any point, including mid-HOLD and mid-debounce.

Synchroniser:
- 2 flops per bit.
- Polarity is normalised to active-high after the second flop.

Debounce, per bit:
- Counter width is $clog2(DEBOUNCE_CYCLES).
- Each edge where the synchronised value equals `btn_stable`: counter <= 0.
- Each edge where it differs: counter increments.
- On the edge where the counter == DEBOUNCE_CYCLES-1 and the values still differ: `btn_stable` flips and the counter <= 0.
- Any agreeing cycle restarts the count, so a glitch shorter than DEBOUNCE_CYCLES never changes `btn_stable`.

FSM (states ARMED, HOLD, WAIT_RELEASE; all outputs registered):
- ARMED, `btn_stable` == 0000: stay.
- ARMED, `btn_stable` exactly one-hot: latch it, drive `direction` = latched value and `key_valid` = 1, hold counter <= 1, go to HOLD.
- ARMED, two or more bits set: go to WAIT_RELEASE with no output.
- HOLD, hold counter < HOLD_CYCLES: increment it and keep `direction`.
- HOLD, otherwise: `direction` <= 0000, go to WAIT_RELEASE.
- HOLD: `key_valid` = 0 in every HOLD cycle after the first.
- HOLD: changes to `btn_stable` during HOLD are ignored.
- WAIT_RELEASE, `btn_stable` == 0000: go to ARMED (earliest re-fire is the following edge). Otherwise stay.

Latency:
- Let edge k be the first edge that samples a new raw level.
- `btn_stable` changes at edge k+1+DEBOUNCE_CYCLES.
- `direction` is first non-zero after edge k+2+DEBOUNCE_CYCLES.
- `direction` is non-zero for exactly HOLD_CYCLES consecutive cycles.

Boundaries:
- A button held through reset fires once after debounce, since stable resets to 0.
- Pressing a second button while the first is in HOLD is ignored. Releasing it while the first stays held does not re-arm the FSM.
- `direction` is never non-one-hot.
- No press can produce two commands without a full release (`btn_stable` == 0000) in between.

Decomposition:
- Shared package `game2048_pkg` holds:
  - constants DIR_NONE, DIR_UP = 4'b0001, DIR_DOWN = 4'b0010, DIR_LEFT = 4'b0100, DIR_RIGHT = 4'b1000;
  - typedef enum dir_fsm_t {ARMED, HOLD, WAIT_RELEASE}.
- The game FSM imports the same package.
- One sub-module, `debounce_bit`: per-bit synchroniser, counter and stable flop, parameterised by DEBOUNCE_CYCLES and BTN_ACTIVE_LOW. It is instantiated 4 times.
- The FSM lives in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, BTN_ACTIVE_LOW=0 unless noted.
1. rst=0 for 3 edges with btn_raw=0000, then rst=1 -> direction=0000, key_valid=0, btn_stable=0000 throughout.
2. btn_raw=0100 from edge k, held 30 cycles -> btn_stable=0100 after edge k+5; direction=0100 after edges k+6..k+8 and 0000 after k+9; key_valid=1 only after k+6; no second command while held. Then release, wait 10 cycles, press 0001 -> exactly one 0001 burst of 3 cycles.
3. btn_raw=0010 for 3 cycles then 0000 -> btn_stable stays 0000, direction never non-zero.
4. btn_raw=0101 held 20 cycles -> no command. Then 0100 held 20 cycles -> still no command. Then 0000 for 10 cycles, then 0100 -> one 0100 burst.
5. Start a 1000 press; assert rst=0 on the second HOLD cycle -> direction=0000 after that edge. Deassert rst with the button still held -> one 1000 burst after the debounce latency, then nothing until release.
6. BTN_ACTIVE_LOW=1: btn_raw idle 1111, drive 0111 -> single direction=1000 burst of 3 cycles, btn_stable=1000.
